// File: rtl/nibble_serial_sub.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub
//
// Multi-cycle subtractor computing a - b four bits per clock. Each nibble is
// formed by a borrow-lookahead slice (a + ~b with carry-in ~borrow_in). The
// nibble borrow is registered and fed into the next nibble on the following
// cycle. A start/busy/done handshake launches an operation and reports it.
//
// Optional feature macro: NIBBLE_SUB_SATURATE_EN
//   defined   : on signed overflow, diff is clamped to the signed max or min.
//               The clamp value depends on the sign of a.
//   undefined : diff is the wrapped two's-complement result.
//
// Parameters
//   WIDTH      operand width, a multiple of 4 and >= 4
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      request; accepted on a rising edge while busy = 0
//   a, b       minuend and subtrahend, captured when start is accepted
//   busy       high while nibbles are being processed
//   done       one-cycle pulse when diff and the flags are valid
//   diff       result; held from done until the next accepted start
//   borrow_out unsigned borrow (a < b)
//   overflow   signed overflow of a - b
//   zero       diff == 0, taken from the (possibly clamped) result
// -----------------------------------------------------------------------------
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int MSB     = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               accept;
    logic               last;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [IDX_W-1:0]   idx;
    logic               bin;

    logic [IDX_W+1:0]   bit_pos;
    logic [3:0]         nib_a;
    logic [3:0]         nib_bn;
    logic [3:0]         g;
    logic [3:0]         p;
    logic [4:0]         c;
    logic [3:0]         nib_diff;
    logic               nib_borrow;
    logic               ovf_next;

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others; blocking here would create
    // order-dependent simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign last = (idx == IDX_W'(NIBBLES - 1));

    // ------------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start held through DONE chains straight into the next run.
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Borrow-lookahead nibble slice: a - b - bin == a + ~b + ~bin
    // ------------------------------------------------------------------
    assign bit_pos = {idx, 2'b00};
    assign nib_a   = a_reg[bit_pos +: 4];
    assign nib_bn  = ~b_reg[bit_pos +: 4];
    assign g       = nib_a & nib_bn;
    assign p       = nib_a ^ nib_bn;

    // Carries expanded as lookahead terms rather than rippled through c[k].
    assign c[0] = ~bin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign nib_diff   = p ^ c[3:0];
    assign nib_borrow = ~c[4];

    // Only meaningful on the last nibble, where nib_diff[3] is the raw MSB.
    assign ovf_next = (a_reg[MSB] ^ b_reg[MSB]) & (nib_diff[3] ^ a_reg[MSB]);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the operand registers are reset along with the rest; they are
    // small flops, not a RAM, so resetting them costs nothing and keeps the
    // post-reset state fully defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            idx        <= '0;
            bin        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
            bin   <= 1'b0;
            diff  <= '0;
        end else if (state == RUN) begin
            diff[bit_pos +: 4] <= nib_diff;
            bin                <= nib_borrow;
            idx                <= idx + 1'b1;
            if (last) begin
                borrow_out <= nib_borrow;
                overflow   <= ovf_next;
`ifdef NIBBLE_SUB_SATURATE_EN
                // Clamp toward the sign of a: positive max or negative min.
                if (ovf_next) begin
                    diff <= a_reg[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        end
    end

    assign zero = (diff == '0);

endmodule

// File: tb/tb_nibble_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_sub
//
// Self-checking bench for nibble_serial_sub (WIDTH = 16). Expected results come
// from a behavioural 17-bit subtraction model, are queued when an operation is
// launched, and are compared when done pulses. Honors NIBBLE_SUB_SATURATE_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nibble_serial_sub;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
        logic             zero;
        int               acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    nibble_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a_in),
        .b          (b_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t             e;
        logic [WIDTH:0]   full;
        full     = {1'b0, x} - {1'b0, y};
        e.diff   = full[WIDTH-1:0];
        e.borrow = full[WIDTH];
        e.ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (e.diff[WIDTH-1] != x[WIDTH-1]);
`ifdef NIBBLE_SUB_SATURATE_EN
        if (e.ovf) e.diff = x[WIDTH-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.zero    = (e.diff == '0);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: compare each done against the oldest queued expectation.
    always @(negedge clk) begin
        check("busy_and_done", {31'd0, busy & done}, 32'd0);
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff",       {16'd0, diff},       {16'd0, e.diff});
                check("borrow_out", {31'd0, borrow_out}, {31'd0, e.borrow});
                check("overflow",   {31'd0, overflow},   {31'd0, e.ovf});
                check("zero",       {31'd0, zero},       {31'd0, e.zero});
                // done is seen after the 4th edge following the accepting edge
                // (5 edges counting the accepting one).
                check("latency",    cyc - e.acc_cyc,     32'd4);
            end
        end
    end

    // Drive a start at the current negedge; the next posedge accepts it.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        start     = 1'b1;
        a_in      = x;
        b_in      = y;
        e         = model(x, y);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        launch(x, y);
        @(negedge clk);
        start = 1'b0;
        // Operand changes after acceptance must not matter.
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        wait_empty();
    endtask

    logic [WIDTH-1:0] vec_a [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555, 16'h7FFF, 16'hA5A5};
    logic [WIDTH-1:0] vec_b [6] = '{16'h0234, 16'h0001, 16'h0001, 16'h5555, 16'hFFFF, 16'h5A5A};

    initial begin
        // Reset state
        #12;
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_done",     {31'd0, done},       32'd0);
        check("rst_diff",     {16'd0, diff},       32'd0);
        check("rst_borrow",   {31'd0, borrow_out}, 32'd0);
        check("rst_overflow", {31'd0, overflow},   32'd0);
        check("rst_zero",     {31'd0, zero},       32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, including the boundary cases
        for (int i = 0; i < 6; i++) do_op(vec_a[i], vec_b[i]);

        // A few random operands
        for (int i = 0; i < 6; i++) do_op(WIDTH'($urandom), WIDTH'($urandom));

        // Back-to-back: 0x5555 - 0x5555, then start held high in DONE
        @(negedge clk);
        launch(16'h5555, 16'h5555);
        @(negedge clk);
        start = 1'b0;
        begin
            int k;
            for (k = 0; k < 20 && !done; k++) @(negedge clk);
            check("b2b_reach_done", {31'd0, done}, 32'd1);
        end
        launch(16'h0003, 16'h0001);
        @(negedge clk);
        check("b2b_no_idle", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_empty();

        // start pulsed while busy must be ignored
        @(negedge clk);
        launch(16'h0010, 16'h0001);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (8) @(negedge clk);
        check("ignored_start_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the third RUN cycle
        @(negedge clk);
        launch(16'h1234, 16'h0001);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_diff", {16'd0, diff}, 32'd0);
        check("arst_zero", {31'd0, zero}, 32'd1);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("arst_still_idle", {31'd0, busy}, 32'd0);

        // Recovery after reset
        do_op(16'h8000, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
